// File: rtl/eq_gain_regfile.sv
// Equaliser gain register file: host-writable shadow gains are copied to the
// active gain set atomically on an audio sample tick once a commit is requested.
module eq_gain_regfile #(
  parameter int N_BANDS = 10,
  parameter int GAIN_W  = 8,
  parameter int ADDR_W  = 8,
  parameter logic [GAIN_W-1:0] GAIN_RST = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic                        re,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [GAIN_W-1:0]           wdata,
  input  logic                        sample_tick,
  output logic [GAIN_W-1:0]           rdata,
  output logic                        rvalid,
  output logic [N_BANDS*GAIN_W-1:0]   gains,
  output logic                        commit_pending,
  output logic                        commit_done,
  output logic                        err
);

  localparam logic [ADDR_W-1:0] CTRL_ADDR   = ADDR_W'(N_BANDS);
  localparam logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(N_BANDS + 1);

  logic [GAIN_W-1:0] shadow_reg [N_BANDS];
  logic [GAIN_W-1:0] active_reg [N_BANDS];
  logic              lock_reg;
  logic              auto_reg;
  logic              pending_reg;
  logic              done_reg;
  logic              err_reg;
  logic [GAIN_W-1:0] rdata_reg;
  logic              rvalid_reg;

  logic              is_gain;
  logic              is_ctrl;
  logic              is_status;
  logic              is_illegal;
  logic              shadow_wr;
  logic              ctrl_wr;
  logic              set_event;
  logic              commit;
  logic              err_set;
  logic              err_clr;
  logic              pending_next;
  logic              err_next;
  logic [GAIN_W-1:0] rd_value;

  assign is_gain    = (addr < CTRL_ADDR);
  assign is_ctrl    = (addr == CTRL_ADDR);
  assign is_status  = (addr == STATUS_ADDR);
  assign is_illegal = (addr > STATUS_ADDR);

  assign shadow_wr = we && is_gain && !lock_reg;
  assign ctrl_wr   = we && is_ctrl;
  assign set_event = (ctrl_wr && wdata[0]) || (auto_reg && shadow_wr);
  assign commit    = sample_tick && pending_reg;

  assign err_set = (we && is_gain && lock_reg) || (we && (is_status || is_illegal))
                 || (re && is_illegal);
  assign err_clr = ctrl_wr && wdata[7];

  // A fresh error in the clearing cycle keeps the flag set.
  assign err_next     = err_set || (err_reg && !err_clr);
  assign pending_next = (pending_reg && !sample_tick) || set_event;

  // Read mux sees pre-edge state, so a same-cycle write is not visible.
  always_comb begin
    rd_value = '0;
    if (is_gain) begin
      for (int k = 0; k < N_BANDS; k++) begin
        if (addr == ADDR_W'(k)) rd_value = shadow_reg[k];
      end
    end else if (is_ctrl) begin
      rd_value[1] = lock_reg;
      rd_value[2] = auto_reg;
    end else if (is_status) begin
      rd_value[0] = pending_reg;
      rd_value[1] = err_reg;
      rd_value[2] = lock_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_BANDS; k++) begin
        shadow_reg[k] <= GAIN_RST;
        active_reg[k] <= GAIN_RST;
      end
    end else begin
      for (int k = 0; k < N_BANDS; k++) begin
        if (commit) active_reg[k] <= shadow_reg[k];
        if (shadow_wr && (addr == ADDR_W'(k))) shadow_reg[k] <= wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_reg    <= 1'b0;
      auto_reg    <= 1'b0;
      pending_reg <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
      rdata_reg   <= '0;
      rvalid_reg  <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        lock_reg <= wdata[1];
        auto_reg <= wdata[2];
      end
      pending_reg <= pending_next;
      done_reg    <= commit;
      err_reg     <= err_next;
      rvalid_reg  <= re;
      if (re) rdata_reg <= rd_value;
    end
  end

  generate
    for (genvar gi = 0; gi < N_BANDS; gi++) begin : g_gains
      assign gains[gi*GAIN_W +: GAIN_W] = active_reg[gi];
    end
  endgenerate

  assign rdata          = rdata_reg;
  assign rvalid         = rvalid_reg;
  assign commit_pending = pending_reg;
  assign commit_done    = done_reg;
  assign err            = err_reg;

endmodule

// File: doc/eq_gain_regfile.md
EQ_GAIN_REGFILE -- requirements
Module: eq_gain_regfile

Interface
REQ-001 Parameter N_BANDS, default 10, number of equaliser band gain registers (2..64).
REQ-002 Parameter GAIN_W, default 8, width of each gain register and of wdata/rdata (>=8).
REQ-003 Parameter ADDR_W, default 8, address width; SHALL satisfy N_BANDS+2 <= 2^ADDR_W.
REQ-004 Parameter GAIN_RST, default 0, reset value of every shadow and active gain register.
REQ-005 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 we  input  1  write strobe, one access per cycle.
REQ-008 re  input  1  read strobe.
REQ-009 addr  input  ADDR_W  register address for we/re.
REQ-010 wdata  input  GAIN_W  write data.
REQ-011 sample_tick  input  1  audio sample strobe, the only commit point.
REQ-012 rdata  output  GAIN_W  registered read data.
REQ-013 rvalid  output  1  high one cycle after an accepted re.
REQ-014 gains  output  N_BANDS*GAIN_W  active gains, band k at bits [k*GAIN_W +: GAIN_W].
REQ-015 commit_pending  output  1  shadow set awaiting commit.
REQ-016 commit_done  output  1  one-cycle pulse on the cycle after active registers were loaded.
REQ-017 err  output  1  sticky illegal-access flag.

Function
REQ-018 Address map: 0..N_BANDS-1 shadow gain k; N_BANDS = CTRL (R/W); N_BANDS+1 = STATUS (read-only); all higher addresses are illegal.
REQ-019 CTRL bits: bit0 COMMIT (write-1 request, self-clearing, reads 0); bit1 LOCK; bit2 AUTO; bit7 ERR_CLR (write-1, reads 0); other bits read 0.
REQ-020 STATUS read value: bit0 = commit_pending, bit1 = err, bit2 = LOCK, others 0.
REQ-021 A write to a gain address with LOCK=0 SHALL load shadow[addr] at the clock edge; with LOCK=1 the shadow SHALL be unchanged and err SHALL set.
REQ-022 CTRL SHALL be writable regardless of LOCK.
REQ-023 Writes to STATUS or to an illegal address SHALL have no effect other than setting err.
REQ-024 Set event = CTRL write with COMMIT=1, or (AUTO=1 and an accepted shadow write).
REQ-025 commit_pending next = (commit_pending AND NOT sample_tick) OR set_event.
REQ-026 When sample_tick=1 and commit_pending=1, all N_BANDS active registers SHALL load the shadow values held before that edge, atomically in one cycle; commit_done SHALL pulse the next cycle.
REQ-027 sample_tick with commit_pending=0 SHALL leave active registers unchanged and SHALL NOT pulse commit_done.
REQ-028 Shadow write coincident with a committing sample_tick: active receives the pre-write shadow value; the new value stays pending only if the cycle is a set event.
REQ-029 gains SHALL change only on a commit edge, never directly on a shadow write.
REQ-030 Read latency SHALL be 1 cycle: rdata/rvalid valid the cycle after re; rdata held until the next accepted read.
REQ-031 Gain-address reads SHALL return the shadow value; illegal-address reads SHALL return 0 and set err.
REQ-032 Simultaneous we and re: both SHALL be performed; the read SHALL return the pre-write value.
REQ-033 err SHALL stay set until a CTRL write with ERR_CLR=1; a new error in the same cycle SHALL win (err stays 1).

Reset
REQ-034 While rst=1: shadow and active = GAIN_RST, CTRL = 0, commit_pending = 0, commit_done = 0, err = 0, rvalid = 0, rdata = 0.
REQ-035 rst SHALL take priority over we, re and sample_tick in the same cycle; a pending commit SHALL be discarded.

Verification
REQ-036 Reset, write 0x40 to addr 2, no tick -> gains band 2 = 0x00; read addr 2 -> rdata 0x40 one cycle later with rvalid=1.
REQ-037 Write 0x11/0x22 to addr 0/1, CTRL=0x01, tick -> both bands update in the same cycle, commit_done pulses once, pending=0.
REQ-038 AUTO=1, write 0x55 to addr 3 in the same cycle as a committing tick -> active band 3 holds the old value, pending stays 1, next tick loads 0x55.
REQ-039 LOCK=1, write addr 0 -> shadow unchanged, err=1; STATUS read = 0x06; CTRL write 0x80 -> err=0.
REQ-040 Read/write addr N_BANDS+5 -> rdata 0, err=1, no register changes.
REQ-041 Pending commit, rst asserted one cycle before tick -> all gains = GAIN_RST, no commit_done after release.
